frame_buf_multi: RTL

FRAME_BUF_MULTI -- requirements
Module: frame_buf_multi

---
 rtl/frame_buf_multi.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/frame_buf_multi.sv
// rtl/frame_buf_multi.sv - multi-buffer frame store with independent write and read frame FSMs
//
// Purpose: NUM_BUFS frame buffers of FRAME_DEPTH words each, held in one array
// addressed as {buffer index, word address}. Frames are written whole into the
// next free buffer and read back whole, in order, from the oldest full buffer.
//
// Ports:
//   clk            single clock, rising edge
//   reset          asynchronous active-low reset
//   wr_en_in       write request, active-low
//   data_in        write data
//   rd_en_in       read request, active-low
//   data_out       registered read data
//   rd_data_valid  data_out carries a word read on the previous edge
//   wr_rdy         at least one buffer is free
//   rd_rdy         at least one buffer is full
//   frame_wr_done  one-cycle pulse after the last word of a frame is written
//   frame_rd_done  one-cycle pulse after the last word of a frame is read
//   full_cnt       number of full buffers, 0..NUM_BUFS
//   overflow       sticky flag, set when a write is dropped
module frame_buf_multi #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 3,
  parameter int BUF_SEL_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     rd_en_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_data_valid,
  output logic                     wr_rdy,
  output logic                     rd_rdy,
  output logic                     frame_wr_done,
  output logic                     frame_rd_done,
  output logic [BUF_SEL_WIDTH:0]   full_cnt,
  output logic                     overflow
);

  localparam int FRAME_DEPTH = 1 << ADDR_WIDTH;
  localparam int NUM_BUFS    = 1 << BUF_SEL_WIDTH;
  localparam logic [BUF_SEL_WIDTH:0] BUFS_CNT = NUM_BUFS[BUF_SEL_WIDTH:0];

  typedef enum logic { WR_IDLE, WR_FILL } wr_state_t;
  typedef enum logic { RD_IDLE, RD_READ } rd_state_t;

  logic [DATA_WIDTH-1:0]    mem [0:NUM_BUFS*FRAME_DEPTH-1];

  wr_state_t                wr_state;
  rd_state_t                rd_state;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [BUF_SEL_WIDTH-1:0] wr_buf;
  logic [BUF_SEL_WIDTH-1:0] rd_buf;

  logic wr_accept;
  logic rd_accept;
  logic wr_last;
  logic rd_last;

  assign wr_rdy    = (full_cnt < BUFS_CNT);
  assign rd_rdy    = (full_cnt != '0);
  assign wr_accept = !wr_en_in && wr_rdy;
  assign rd_accept = !rd_en_in && rd_rdy;
  assign wr_last   = wr_accept && (wr_addr == '1);
  assign rd_last   = rd_accept && (rd_addr == '1);

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[{wr_buf, wr_addr}] <= data_in;
    end
  end

  // Write FSM: the first word of a frame is stored on the IDLE edge itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state      <= WR_IDLE;
      wr_addr       <= '0;
      wr_buf        <= '0;
      frame_wr_done <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      frame_wr_done <= 1'b0;
      if (!wr_en_in && !wr_rdy) begin
        overflow <= 1'b1;
      end
      if (wr_accept) begin
        if (wr_addr == '1) begin
          wr_addr       <= '0;
          wr_buf        <= wr_buf + 1'b1;
          frame_wr_done <= 1'b1;
          wr_state      <= WR_IDLE;
        end else begin
          wr_addr  <= wr_addr + 1'b1;
          wr_state <= WR_FILL;
        end
      end
    end
  end

  // Read FSM; a full buffer is never the one being written, so no bypass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state      <= RD_IDLE;
      rd_addr       <= '0;
      rd_buf        <= '0;
      frame_rd_done <= 1'b0;
      rd_data_valid <= 1'b0;
      data_out      <= '0;
    end else begin
      frame_rd_done <= 1'b0;
      rd_data_valid <= rd_accept;
      if (rd_accept) begin
        data_out <= mem[{rd_buf, rd_addr}];
        if (rd_addr == '1) begin
          rd_addr       <= '0;
          rd_buf        <= rd_buf + 1'b1;
          frame_rd_done <= 1'b1;
          rd_state      <= RD_IDLE;
        end else begin
          rd_addr  <= rd_addr + 1'b1;
          rd_state <= RD_READ;
        end
      end
    end
  end

  // Simultaneous write and read completion leaves the count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_cnt <= '0;
    end else begin
      case ({wr_last, rd_last})
        2'b10:   full_cnt <= full_cnt + 1'b1;
        2'b01:   full_cnt <= full_cnt - 1'b1;
        default: full_cnt <= full_cnt;
      endcase
    end
  end

endmodule
